// File: rtl/vram_fetch_arbiter_if.sv
// Host write port of the framebuffer arbiter: valid/ready handshake
// carrying one 16-bit word and its 13-bit word address.
interface vram_fetch_arbiter_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vram_fetch_arbiter.sv
// Single-port framebuffer arbiter: fixed scanout read slots, host writes drained from a FIFO.
// Define WR_VBLANK_ONLY_EN to hold host writes until vertical blanking.
module vram_fetch_arbiter #(
    parameter int WQ_DEPTH = 4,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                hpos,
    input  logic [9:0]                vpos,
    input  logic                      display_on,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [12:0]               mem_addr,
    output logic [15:0]               mem_wdata,
    input  logic [15:0]               mem_rdata,
    vram_fetch_arbiter_if.slave       wr,
    output logic [3:0]                pixel,
    output logic [$clog2(WQ_DEPTH):0] wq_level
);
    localparam int AW = $clog2(WQ_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(WQ_DEPTH);

    logic [12:0] q_addr [WQ_DEPTH];
    logic [15:0] q_data [WQ_DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   level;
    logic [15:0]   word_q;
    logic          rd_d;

    logic        ds;
    logic        in_line;
    logic        eol;
    logic [6:0]  w;
    logic [9:0]  next_line;
    logic [9:0]  line;
    logic [6:0]  word_idx;
    logic [12:0] rd_addr;
    logic        rd_act;
    logic        wr_slot;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    // Slot at hpos[3:0]==14 fetches the word shown from the next hpos[3:0]==0.
    always_comb begin
        ds        = hpos[3:0] == 4'd14;
        w         = 7'((11'(hpos) + 11'd2) >> 4);
        in_line   = (w < 7'd40) && (vpos < 10'd480);
        eol       = hpos == 10'(H_TOTAL - 2);
        next_line = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
        rd_act    = ds && (in_line || (eol && next_line < 10'd480));
        line      = in_line ? vpos : next_line;
        word_idx  = in_line ? w : 7'd0;
        rd_addr   = 13'(line >> 2) * 13'd40 + 13'(word_idx);
    end

    always_comb begin
`ifdef WR_VBLANK_ONLY_EN
        wr_slot = vpos >= 10'd480;
`else
        wr_slot = 1'b1;
`endif
        full  = level == FULL_LVL;
        empty = level == '0;
        push  = wr.wr_valid && !full;
        pop   = !rst && !rd_act && !empty && wr_slot;
    end

    always_comb begin
        mem_en    = !rst && (rd_act || pop);
        mem_we    = pop;
        mem_addr  = rd_act ? rd_addr : q_addr[head];
        mem_wdata = q_data[head];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            level  <= '0;
            word_q <= '0;
            rd_d   <= 1'b0;
        end else begin
            rd_d <= rd_act;
            if (rd_d) word_q <= mem_rdata;
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= wr.wr_addr;
            q_data[tail] <= wr.wr_data;
        end
    end

    // Leftmost pixel sits in bits [15:12].
    assign pixel       = display_on ? word_q[{~hpos[3:2], 2'b11} -: 4] : 4'd0;
    assign wr.wr_ready = !full;
    assign wq_level    = level;
endmodule
